// File: rtl/tag_lookup_controller.sv
// tag_lookup_controller: initiator side of the cache tag store.
// Looks up the set entry for each request and compares its tag. A miss runs a
// refill handshake and then allocates the entry. A flush pulse starts a sweep
// that invalidates every entry.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting; accepts a lookup (issuing the tag read) or starts a flush
// COMPARE  | tag read data valid; decide hit or miss
// REFILL   | refill_req_o held until refill_done_i
// ALLOCATE | write {1, tag} into the set, report miss
// FLUSH    | write zero into every set, one per cycle
module tag_lookup_controller #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int TAG_SIZE     = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  req_address_i,
    output logic                   req_ready_o,
    output logic                   resp_valid_o,
    output logic                   resp_hit_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   refill_req_o,
    output logic [ADDR_WIDTH-1:0]  refill_address_o,
    input  logic                   refill_done_i,
    output logic [INDEX_WIDTH-1:0] tag_address_o,
    output logic                   tag_read_o,
    output logic                   tag_write_o,
    output logic [TAG_SIZE:0]      tag_write_data_o,
    input  logic [TAG_SIZE:0]      tag_read_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        REFILL,
        ALLOCATE,
        FLUSH
    } state_t;

    // One extra counter bit so the last set is found by compare, not by wrap.
    localparam logic [INDEX_WIDTH:0] FLUSH_LAST = {1'b0, {INDEX_WIDTH{1'b1}}};

    state_t                 state;
    state_t                 state_next;
    logic                   flush_pending;
    logic [TAG_SIZE-1:0]    tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH:0]   counter;
    logic                   hit;
    logic [TAG_SIZE-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic                   unused_offset;

    assign req_tag       = req_address_i[ADDR_WIDTH-1 -: TAG_SIZE];
    assign req_index     = req_address_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign unused_offset = ^req_address_i[OFFSET_WIDTH-1:0];
    assign hit           = tag_read_data_i[TAG_SIZE] &&
                           (tag_read_data_i[TAG_SIZE-1:0] == tag_q);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and tag-memory strobes; everything is held quiet during reset.
    always_comb begin
        state_next       = state;
        req_ready_o      = 1'b0;
        tag_read_o       = 1'b0;
        tag_write_o      = 1'b0;
        tag_address_o    = '0;
        tag_write_data_o = '0;
        if (rst_n_i) begin
            case (state)
                IDLE: begin
                    req_ready_o = !flush_pending && !flush_i;
                    if (flush_i || flush_pending) begin
                        state_next = FLUSH;
                    end else if (req_valid_i) begin
                        tag_read_o    = 1'b1;
                        tag_address_o = req_index;
                        state_next    = COMPARE;
                    end
                end
                COMPARE: begin
                    state_next = hit ? IDLE : REFILL;
                end
                REFILL: begin
                    if (refill_done_i) begin
                        state_next = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    tag_write_o      = 1'b1;
                    tag_address_o    = index_q;
                    tag_write_data_o = {1'b1, tag_q};
                    state_next       = IDLE;
                end
                FLUSH: begin
                    tag_write_o   = 1'b1;
                    tag_address_o = counter[INDEX_WIDTH-1:0];
                    if (counter == FLUSH_LAST) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered outputs, request latch, flush counter and pending flush.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            resp_valid_o     <= 1'b0;
            resp_hit_o       <= 1'b0;
            flush_done_o     <= 1'b0;
            refill_req_o     <= 1'b0;
            refill_address_o <= '0;
            flush_pending    <= 1'b0;
            tag_q            <= '0;
            index_q          <= '0;
            counter          <= '0;
        end else begin
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            flush_done_o <= 1'b0;
            // A pulse during an active sweep is already covered by it.
            if (state == IDLE && (flush_i || flush_pending)) begin
                flush_pending <= 1'b0;
            end else if (flush_i && state != FLUSH) begin
                flush_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (state_next == COMPARE) begin
                        tag_q   <= req_tag;
                        index_q <= req_index;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        resp_valid_o <= 1'b1;
                        resp_hit_o   <= 1'b1;
                    end else begin
                        refill_req_o     <= 1'b1;
                        refill_address_o <= {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
                    end
                end
                REFILL: begin
                    if (refill_done_i) begin
                        refill_req_o <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    resp_valid_o <= 1'b1;
                end
                FLUSH: begin
                    counter <= counter + 1'b1;
                    if (counter == FLUSH_LAST) begin
                        flush_done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_controller.sv
// Bench for tag_lookup_controller: tag memory stub, timeline-based reference
// model with a per-cycle compare process, directed scenarios, random traffic.
module tb_tag_lookup_controller;
    localparam int AW = 32;
    localparam int IW = 7;
    localparam int OW = 5;
    localparam int TS = AW - IW - OW;
    localparam int DEPTH = 1 << IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_hit;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          refill_req;
    logic [AW-1:0] refill_address;
    logic          refill_done = 1'b0;
    logic [IW-1:0] tag_address;
    logic          tag_read;
    logic          tag_write;
    logic [TS:0]   tag_write_data;
    logic [TS:0]   tag_read_data = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    tag_lookup_controller dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .req_valid_i      (req_valid),
        .req_address_i    (req_address),
        .req_ready_o      (req_ready),
        .resp_valid_o     (resp_valid),
        .resp_hit_o       (resp_hit),
        .flush_i          (flush),
        .flush_done_o     (flush_done),
        .refill_req_o     (refill_req),
        .refill_address_o (refill_address),
        .refill_done_i    (refill_done),
        .tag_address_o    (tag_address),
        .tag_read_o       (tag_read),
        .tag_write_o      (tag_write),
        .tag_write_data_o (tag_write_data),
        .tag_read_data_i  (tag_read_data)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index: the value seen at a negedge names the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Tag memory stub with registered read data.
    logic [TS:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (tag_write) mem[tag_address] <= tag_write_data;
        if (tag_read) tag_read_data <= mem[tag_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: schedules of expected events in cycle numbers plus a
    // golden copy of the tag store.
    logic [TS:0]   gold [DEPTH] = '{default: '0};
    int            busy_until = 0;
    int            acc_cycle = -100;
    int            resp_cycle = -100;
    int            alloc_cycle = -100;
    int            flush_f = -1000;
    bit            in_refill = 0;
    bit            pending = 0;
    bit            m_hit = 0;
    logic [TS-1:0] m_tag = '0;
    logic [IW-1:0] m_idx = '0;

    // Per-cycle compare of every output against the model, then model advance.
    always @(negedge clk) begin
        int            c;
        bit            flushing, idle, e_ready, accept, e_write, take_flush;
        logic [IW-1:0] e_addr;
        logic [TS:0]   e_wdata;
        logic [TS-1:0] r_tag;
        logic [IW-1:0] r_idx;
        c = cyc;
        r_tag = req_address[AW-1 -: TS];
        r_idx = req_address[OW +: IW];
        flushing = (c >= flush_f + 1) && (c <= flush_f + DEPTH);
        idle = !in_refill && (c >= busy_until);
        e_ready = rst_n && idle && !pending && !flush;
        take_flush = rst_n && idle && (flush || pending);
        accept = e_ready && req_valid;
        e_write = rst_n && ((c == alloc_cycle) || flushing);
        e_addr = '0;
        e_wdata = '0;
        if (accept) e_addr = r_idx;
        else if (rst_n && c == alloc_cycle) begin
            e_addr = m_idx;
            e_wdata = {1'b1, m_tag};
        end else if (rst_n && flushing) e_addr = IW'(c - flush_f - 1);

        check("req_ready", req_ready, e_ready);
        check("tag_read", tag_read, accept);
        check("tag_write", tag_write, e_write);
        check("tag_address", tag_address, e_addr);
        check("tag_write_data", tag_write_data, e_wdata);
        check("refill_req", refill_req, in_refill && (c >= acc_cycle + 2));
        if (in_refill && (c >= acc_cycle + 2))
            check("refill_address", refill_address, {m_tag, m_idx, {OW{1'b0}}});
        check("resp_valid", resp_valid, c == resp_cycle);
        if (c == resp_cycle) check("resp_hit", resp_hit, m_hit);
        check("flush_done", flush_done, c == flush_f + DEPTH + 1);

        if (e_write) gold[e_addr] = e_wdata;
        if (!rst_n) begin
            in_refill = 0;
            pending = 0;
            busy_until = c + 1;
            acc_cycle = -100;
            resp_cycle = -100;
            alloc_cycle = -100;
            flush_f = -1000;
        end else begin
            if (take_flush) begin
                flush_f = c;
                busy_until = c + DEPTH + 1;
                pending = 0;
            end else if (flush && !flushing) begin
                pending = 1;
            end
            if (accept) begin
                m_tag = r_tag;
                m_idx = r_idx;
                acc_cycle = c;
                busy_until = c + 2;
                if (gold[r_idx][TS] && gold[r_idx][TS-1:0] == r_tag) begin
                    resp_cycle = c + 2;
                    m_hit = 1;
                end else begin
                    in_refill = 1;
                end
            end else if (in_refill && (c >= acc_cycle + 2) && refill_done) begin
                in_refill = 0;
                alloc_cycle = c + 1;
                resp_cycle = c + 2;
                m_hit = 0;
                busy_until = c + 2;
            end
        end
    end

    // Results of the last directed lookup (stimulus process only).
    int            t_acc, lk_lat, lk_q, lk_wcyc, lk_resp;
    bit            lk_hit;
    logic [IW-1:0] lk_waddr;
    logic [TS:0]   lk_wdata;
    logic [AW-1:0] lk_raddr;

    task automatic send(input logic [AW-1:0] a);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_address = a;
        t_acc = -1;
        for (int i = 0; i < 300 && t_acc < 0; i++) begin
            @(negedge clk);
            if (req_ready) t_acc = cyc;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        check("accept_seen", t_acc >= 0, 1);
    endtask

    task automatic lookup(input logic [AW-1:0] a, input int done_delay, input int flush_delay);
        send(a);
        lk_hit = 0; lk_lat = -1; lk_q = -1; lk_wcyc = -1; lk_resp = -1;
        lk_waddr = '0; lk_wdata = '0; lk_raddr = '0;
        for (int i = 0; i < 300 && lk_lat < 0 && t_acc >= 0; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            refill_done = (lk_q >= 0) && (cyc == lk_q + done_delay);
            flush = (lk_q >= 0) && (cyc == lk_q + flush_delay);
            @(negedge clk);
            if (refill_req && lk_q < 0) begin
                lk_q = cyc;
                lk_raddr = refill_address;
            end
            if (tag_write && lk_wcyc < 0) begin
                lk_wcyc = cyc;
                lk_waddr = tag_address;
                lk_wdata = tag_write_data;
            end
            if (resp_valid) begin
                lk_resp = cyc;
                lk_lat = cyc - t_acc;
                lk_hit = resp_hit;
            end
        end
        refill_done = 1'b0;
        flush = 1'b0;
        check("resp_seen", lk_lat >= 0, 1);
    endtask

    int q_rst;
    int nresp, fw, nw, nz, fd, wr_in_rst;
    int accs[$];

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_refill_req", refill_req, 0);
        check("rst_refill_address", refill_address, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_tag_strobes", {tag_read, tag_write}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Cold miss with done three cycles after refill_req rises
        lookup(32'h0000_1040, 3, -1);
        check("t1_hit", lk_hit, 0);
        check("t1_req_rise", lk_q - t_acc, 2);
        check("t1_refill_address", lk_raddr, 32'h0000_1040);
        check("t1_write_cycle", lk_wcyc - lk_q, 4);
        check("t1_write_addr", lk_waddr, 2);
        check("t1_write_data", lk_wdata, 21'h1_00001);
        check("t1_resp_cycle", lk_resp - lk_q, 5);

        // Hit in the same line
        lookup(32'h0000_1044, 3, -1);
        check("t2_hit", lk_hit, 1);
        check("t2_latency", lk_lat, 2);
        check("t2_no_refill", lk_q, -1);

        // Conflicting tag overwrites the set, original then misses
        lookup(32'h0000_3040, 2, -1);
        check("t3_hit", lk_hit, 0);
        check("t3_write_data", lk_wdata, 21'h1_00003);
        check("t3_write_addr", lk_waddr, 2);
        lookup(32'h0000_1040, 1, -1);
        check("t3_reload_hit", lk_hit, 0);

        // Back-to-back hits with request held
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_address = 32'h0000_1040;
        begin
            int s;
            s = cyc;
            nresp = 0;
            accs = {};
            for (int i = 0; i < 9; i++) begin
                if (i == 6) req_valid = 1'b0;
                @(negedge clk);
                if (req_valid && req_ready) accs.push_back(cyc - s);
                if (resp_valid) nresp++;
                @(posedge clk); #1;
            end
        end
        check("b2b_accepts", accs.size(), 3);
        check("b2b_acc1", (accs.size() > 1) ? accs[1] : -1, 2);
        check("b2b_acc2", (accs.size() > 2) ? accs[2] : -1, 4);
        check("b2b_responses", nresp, 3);

        // Flush pulse during refill: response first, then the sweep
        lookup(32'h0000_5040, 3, 1);
        check("t5_hit", lk_hit, 0);
        check("t5_ready_at_resp", req_ready, 0);
        fw = -1; nw = 0; nz = 0; fd = -1;
        for (int i = 0; i < 300 && fd < 0; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (tag_write) begin
                nw++;
                if (fw < 0) fw = cyc;
                if (tag_write_data != '0) nz++;
            end
            if (flush_done) fd = cyc;
        end
        check("t5_flush_done_seen", fd >= 0, 1);
        check("t5_flush_writes", nw, 128);
        check("t5_flush_nonzero", nz, 0);
        check("t5_first_write", fw - lk_resp, 1);
        check("t5_done_cycle", fd - lk_resp, 129);
        lookup(32'h0000_1040, 1, -1);
        check("t5_after_flush_hit", lk_hit, 0);

        // Reset during refill, with a done that must be ignored
        send(32'h0000_7040);
        q_rst = -1;
        for (int i = 0; i < 20 && q_rst < 0; i++) begin
            @(negedge clk);
            if (refill_req) q_rst = cyc;
            else begin @(posedge clk); #1; end
        end
        check("t6_refill_seen", q_rst >= 0, 1);
        wr_in_rst = 0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        refill_done = 1'b1;
        @(negedge clk);
        if (tag_write) wr_in_rst++;
        @(posedge clk); #1;
        refill_done = 1'b0;
        @(negedge clk);
        check("t6_refill_dropped", refill_req, 0);
        if (tag_write) wr_in_rst++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", req_ready, 1);
        if (tag_write) wr_in_rst++;
        check("t6_no_tag_write", wr_in_rst, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 99) < 60);
            req_address = {TS'($urandom_range(0, 3)), IW'($urandom_range(0, 3)), OW'($urandom)};
            flush = ($urandom_range(0, 199) == 0);
            refill_done = ($urandom_range(0, 2) == 0);
            rst_n = !($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 1'b0;
        flush = 1'b0;
        refill_done = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
